// File: rtl/j1_code_loader_pkg.sv
// Shared types and widths for the J1 boot loader.
// State enum plus the byte and code-word widths.
package j1_code_loader_pkg;

  localparam int CODE_DATA_W = 16;
  localparam int BYTE_W      = 8;

  typedef enum logic [2:0] {
    HDR,
    DATA,
    CSUM,
    RUN,
    ERR
  } state_t;

endpackage

// File: rtl/j1_loader_wdt.sv
// Inter-byte watchdog for the J1 boot loader.
// Counts idle cycles while enabled; any accepted byte restarts it.
module j1_loader_wdt #(
  parameter int TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic kick,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // Fires during the TIMEOUT-th idle cycle so the FSM leaves on that edge
  assign expired = enable && !kick
                && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (!enable || kick || expired)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/j1_code_loader.sv
// J1 boot sequencer: receives a framed image over a byte stream,
// writes it to code RAM, checks the sum, then releases the CPU.
module j1_code_loader
  import j1_code_loader_pkg::*;
#(
  parameter int ADDR_W  = 13,
  parameter int TIMEOUT = 1000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BYTE_W-1:0]      rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  input  logic                   reload,
  output logic                   cpu_resetq,
  output logic                   code_wr,
  output logic [ADDR_W-1:0]      code_waddr,
  output logic [CODE_DATA_W-1:0] code_wdata,
  output logic                   done,
  output logic                   err
);

  state_t state, state_n;
  logic   phase, phase_n;

  logic [BYTE_W-1:0]      lo_byte;
  logic [ADDR_W:0]        addr;
  logic [ADDR_W:0]        count;
  logic [CODE_DATA_W-1:0] acc;
  logic [CODE_DATA_W-1:0] word;

  logic accept, expired, wdt_en;
  logic last_word, hdr_big;

  assign accept    = rx_valid && rx_ready;
  assign word      = {rx_data, lo_byte};
  assign last_word = (addr + (ADDR_W+1)'(1)) == count;
  assign hdr_big   = {16'b0, word} > (32'd1 << ADDR_W);

  j1_loader_wdt #(
    .TIMEOUT(TIMEOUT)
  ) u_wdt (
    .clk    (clk),
    .reset  (reset),
    .kick   (accept),
    .enable (wdt_en),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= HDR;
      phase <= 1'b0;
    end else begin
      state <= state_n;
      phase <= phase_n;
    end
  end

  always_comb begin
    state_n = state;
    phase_n = phase;
    if (reload || expired) begin
      state_n = HDR;
      phase_n = 1'b0;
    end else if (accept) begin
      phase_n = ~phase;
      unique case (state)
        HDR:
          if (phase)
            state_n = hdr_big ? ERR
                    : (word == '0) ? CSUM : DATA;
        DATA:
          if (phase && last_word)
            state_n = CSUM;
        CSUM:
          if (phase)
            state_n = (word == acc) ? RUN : ERR;
        default:
          phase_n = 1'b0;
      endcase
    end
  end

  always_comb begin
    rx_ready = (state != RUN);
    wdt_en   = (state == HDR && phase)
            || state == DATA
            || state == CSUM;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lo_byte    <= '0;
      addr       <= '0;
      count      <= '0;
      acc        <= '0;
      code_wr    <= 1'b0;
      code_waddr <= '0;
      code_wdata <= '0;
    end else begin
      code_wr <= 1'b0;
      if (accept && !phase)
        lo_byte <= rx_data;
      if (reload || expired) begin
        addr  <= '0;
        count <= '0;
        acc   <= '0;
      end else if (accept && phase) begin
        unique case (state)
          HDR: begin
            count <= (ADDR_W+1)'(word);
            addr  <= '0;
            acc   <= '0;
          end
          DATA: begin
            code_wr    <= 1'b1;
            code_waddr <= addr[ADDR_W-1:0];
            code_wdata <= word;
            acc        <= acc + word;
            addr       <= addr + (ADDR_W+1)'(1);
          end
          default: ;
        endcase
      end
    end
  end

  // Status follows the next state so release and reload land one cycle later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_resetq <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      cpu_resetq <= (state_n == RUN);
      done       <= (state_n == RUN);
      err        <= (state_n == ERR);
    end
  end

endmodule

// File: tb/tb_j1_code_loader.sv
// Bench for j1_code_loader: vector table, corner sequences,
// and randomized frames against an arithmetic frame model.
module tb_j1_code_loader;

  localparam int ADDR_W  = 13;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              reload = 1'b0;
  logic              cpu_resetq;
  logic              code_wr;
  logic [ADDR_W-1:0] code_waddr;
  logic [15:0]       code_wdata;
  logic              done;
  logic              err;

  int checks = 0;
  int failures = 0;

  logic [31:0] wr_q[$];

  j1_code_loader #(
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .reload    (reload),
    .cpu_resetq(cpu_resetq),
    .code_wr   (code_wr),
    .code_waddr(code_waddr),
    .code_wdata(code_wdata),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (code_wr === 1'b1)
      wr_q.push_back(32'({code_waddr, code_wdata}));

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  typedef struct {
    logic [15:0]      n;
    logic [2:0][15:0] w;
    logic [15:0]      csum;
    bit               hdr_only;
    bit               exp_done;
    bit               exp_err;
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t mk(input logic [15:0] n,
                              input logic [15:0] w0, w1, w2,
                              input logic [15:0] cs,
                              input bit ho, d, e);
    vec_t v;
    v.n = n;
    v.w[0] = w0;
    v.w[1] = w1;
    v.w[2] = w2;
    v.csum = cs;
    v.hdr_only = ho;
    v.exp_done = d;
    v.exp_err = e;
    return v;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk);
    #1 reload = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cpu_resetq"}, 32'(cpu_resetq), 32'd0);
    chk({tag, "_code_wr"}, 32'(code_wr), 32'd0);
    chk({tag, "_code_waddr"}, 32'(code_waddr), 32'd0);
    chk({tag, "_code_wdata"}, 32'(code_wdata), 32'd0);
    chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic check_writes(input string tag,
                              input logic [15:0] ws[$]);
    chk({tag, "_wr_count"}, 32'(wr_q.size()), 32'(ws.size()));
    for (int i = 0; i < ws.size() && i < wr_q.size(); i++)
      chk({tag, "_wr_entry"}, wr_q[i],
          32'({ADDR_W'(i), ws[i]}));
  endtask

  initial begin
    logic [15:0] exp_ws[$];
    logic [15:0] w;
    vec_t v;

    vecs[0] = mk(16'd3, 16'h8001, 16'h6000, 16'h0000,
                 16'hE001, 0, 1, 0);
    vecs[1] = mk(16'd3, 16'h8001, 16'h6000, 16'h0000,
                 16'hE000, 0, 0, 1);
    vecs[2] = mk(16'h2001, 0, 0, 0, 0, 1, 0, 1);
    vecs[3] = mk(16'd0, 0, 0, 0, 16'h0000, 0, 1, 0);
    vecs[4] = mk(16'd1, 16'hFFFF, 0, 0, 16'hFFFF, 0, 1, 0);
    vecs[5] = mk(16'd2, 16'hFFFF, 16'h0002, 0,
                 16'h0001, 0, 1, 0);

    #1 check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
    idle(1);

    foreach (vecs[k]) begin
      v = vecs[k];
      do_reload();
      wr_q.delete();
      send_word(v.n);
      if (!v.hdr_only) begin
        for (int i = 0; i < int'(v.n); i++) begin
          w = v.w[i];
          send_word(w);
          chk("vec_wr_strobe", 32'(code_wr), 32'd1);
          chk("vec_wr_addr", 32'(code_waddr), 32'(i));
          chk("vec_wr_data", 32'(code_wdata), 32'(w));
        end
        send_word(v.csum);
      end
      chk("vec_done", 32'(done), 32'(v.exp_done));
      chk("vec_err", 32'(err), 32'(v.exp_err));
      chk("vec_cpu_resetq", 32'(cpu_resetq), 32'(v.exp_done));
      if (v.exp_err) begin
        for (int i = 0; i < 4; i++) begin
          chk("err_rx_ready", 32'(rx_ready), 32'd1);
          send_byte(8'(i + 8'h5A));
        end
        chk("err_sticky", 32'(err), 32'd1);
        chk("err_cpu_held", 32'(cpu_resetq), 32'd0);
      end
      if (v.exp_done)
        chk("run_rx_ready", 32'(rx_ready), 32'd0);
      idle(2);
      chk("vec_wr_total", 32'(wr_q.size()),
          v.hdr_only ? 32'd0 : 32'(v.n));
    end

    // N at exact capacity must not be rejected
    do_reload();
    send_word(16'h2000);
    chk("cap_hdr_no_err", 32'(err), 32'd0);

    // reload from RUN, then reload racing an accepted byte
    do_reload();
    send_word(16'h0000);
    send_word(16'h0000);
    chk("run_done", 32'(done), 32'd1);
    do_reload();
    chk("reload_cpu_resetq", 32'(cpu_resetq), 32'd0);
    chk("reload_done", 32'(done), 32'd0);
    @(negedge clk);
    reload = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'h01;
    @(posedge clk);
    #1 reload = 1'b0;
    rx_valid = 1'b0;
    wr_q.delete();
    send_word(16'h0001);
    send_word(16'h1234);
    send_word(16'h1234);
    chk("race_done", 32'(done), 32'd1);
    idle(2);
    exp_ws = '{16'h1234};
    check_writes("race", exp_ws);

    // watchdog: stall mid-frame, then a clean frame
    do_reload();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h11);
    idle(16);
    wr_q.delete();
    send_word(16'h0002);
    send_word(16'hABCD);
    send_word(16'h0102);
    send_word(16'hACCF);
    chk("wdt_done", 32'(done), 32'd1);
    chk("wdt_err", 32'(err), 32'd0);
    idle(2);
    exp_ws = '{16'hABCD, 16'h0102};
    check_writes("wdt", exp_ws);

    // async reset while a DATA/hi byte is presented
    do_reload();
    wr_q.delete();
    send_word(16'h0003);
    send_word(16'h5A5A);
    send_word(16'h6677);
    send_byte(8'h33);
    @(negedge clk);
    rx_data = 8'h44;
    rx_valid = 1'b1;
    #2 reset = 1'b1;
    #1 check_reset_outputs("async");
    @(posedge clk);
    #1 chk("async_no_write", 32'(code_wr), 32'd0);
    rx_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    idle(2);
    chk("async_wr_total", 32'(wr_q.size()), 32'd2);

    // randomized frames against an arithmetic model
    for (int t = 0; t < 40; t++) begin
      int n, sum;
      bit big, bad;
      logic [15:0] cs;
      exp_ws.delete();
      big = ($urandom_range(0, 9) == 0);
      bad = ($urandom_range(0, 3) == 0);
      n = big ? 8193 + $urandom_range(0, 5000)
              : $urandom_range(0, 6);
      sum = 0;
      if (!big)
        for (int i = 0; i < n; i++) begin
          w = 16'($urandom);
          exp_ws.push_back(w);
          sum = (sum + int'(w)) % 65536;
        end
      cs = 16'(sum);
      if (bad)
        cs = cs ^ (16'd1 << $urandom_range(0, 15));
      do_reload();
      wr_q.delete();
      send_word(16'(n));
      if (!big) begin
        foreach (exp_ws[i]) begin
          idle($urandom_range(0, 3));
          send_byte(exp_ws[i][7:0]);
          idle($urandom_range(0, 3));
          send_byte(exp_ws[i][15:8]);
        end
        idle($urandom_range(0, 3));
        send_word(cs);
      end
      chk("rnd_done", 32'(done), 32'(!big && !bad));
      chk("rnd_err", 32'(err), 32'(big || bad));
      chk("rnd_cpu_resetq", 32'(cpu_resetq),
          32'(!big && !bad));
      idle(2);
      if (big)
        exp_ws.delete();
      check_writes("rnd", exp_ws);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
